// File: rtl/bus_load_bank.sv
// 32-entry register bank loaded from the datapath bus with byte enables.
// All entries are driven out in parallel for the bus-source select path.
module bus_load_bank #(
  parameter int DATA_W  = 32,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              wr_en,
  input  logic [4:0]        wr_sel,
  input  logic [DATA_W/8-1:0] wr_be,
  output logic [DATA_W-1:0] r0,
  output logic [DATA_W-1:0] r1,
  output logic [DATA_W-1:0] r2,
  output logic [DATA_W-1:0] r3,
  output logic [DATA_W-1:0] r4,
  output logic [DATA_W-1:0] r5,
  output logic [DATA_W-1:0] r6,
  output logic [DATA_W-1:0] r7,
  output logic [DATA_W-1:0] r8,
  output logic [DATA_W-1:0] r9,
  output logic [DATA_W-1:0] r10,
  output logic [DATA_W-1:0] r11,
  output logic [DATA_W-1:0] r12,
  output logic [DATA_W-1:0] r13,
  output logic [DATA_W-1:0] r14,
  output logic [DATA_W-1:0] r15,
  output logic [DATA_W-1:0] r16,
  output logic [DATA_W-1:0] r17,
  output logic [DATA_W-1:0] r18,
  output logic [DATA_W-1:0] r19,
  output logic [DATA_W-1:0] r20,
  output logic [DATA_W-1:0] r21,
  output logic [DATA_W-1:0] r22,
  output logic [DATA_W-1:0] r23,
  output logic [DATA_W-1:0] r24,
  output logic [DATA_W-1:0] r25,
  output logic [DATA_W-1:0] r26,
  output logic [DATA_W-1:0] r27,
  output logic [DATA_W-1:0] r28,
  output logic [DATA_W-1:0] r29,
  output logic [DATA_W-1:0] r30,
  output logic [DATA_W-1:0] r31,
  output logic [31:0]       valid,
  output logic              wr_ack,
  output logic [4:0]        last_sel
);

  localparam int NB = DATA_W / 8;

  typedef enum logic {
    IDLE,
    WRITE
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       ld;
  logic [DATA_W-1:0] mem_q [32];
  logic [31:0]       valid_q, valid_d;
  logic [4:0]        sel_q, sel_d;

  // Entry 0 never loads when hardwired, so its valid bit never sets either.
  always_comb begin
    ld = '0;
    ld[wr_sel] = wr_en;
    if (ZERO_R0) ld[0] = 1'b0;
    state_d = wr_en ? WRITE : IDLE;
    sel_d   = wr_en ? wr_sel : sel_q;
    valid_d = valid_q;
    if (|wr_be) valid_d = valid_q | ld;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      valid_q <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int n = 0; n < 32; n++) mem_q[n] <= '0;
    end else begin
      for (int n = 0; n < 32; n++)
        for (int k = 0; k < NB; k++)
          if (ld[n] && wr_be[k])
            mem_q[n][8*k +: 8] <= bus_in[8*k +: 8];
    end
  end

  assign wr_ack   = (state_q == WRITE);
  assign last_sel = sel_q;
  assign valid    = valid_q & ~{31'b0, ZERO_R0};

  assign r0  = ZERO_R0 ? '0 : mem_q[0];
  assign r1  = mem_q[1];
  assign r2  = mem_q[2];
  assign r3  = mem_q[3];
  assign r4  = mem_q[4];
  assign r5  = mem_q[5];
  assign r6  = mem_q[6];
  assign r7  = mem_q[7];
  assign r8  = mem_q[8];
  assign r9  = mem_q[9];
  assign r10 = mem_q[10];
  assign r11 = mem_q[11];
  assign r12 = mem_q[12];
  assign r13 = mem_q[13];
  assign r14 = mem_q[14];
  assign r15 = mem_q[15];
  assign r16 = mem_q[16];
  assign r17 = mem_q[17];
  assign r18 = mem_q[18];
  assign r19 = mem_q[19];
  assign r20 = mem_q[20];
  assign r21 = mem_q[21];
  assign r22 = mem_q[22];
  assign r23 = mem_q[23];
  assign r24 = mem_q[24];
  assign r25 = mem_q[25];
  assign r26 = mem_q[26];
  assign r27 = mem_q[27];
  assign r28 = mem_q[28];
  assign r29 = mem_q[29];
  assign r30 = mem_q[30];
  assign r31 = mem_q[31];

endmodule

// File: tb/tb_bus_load_bank.sv
// Directed bench for bus_load_bank: one bank with a writable entry 0,
// one with entry 0 hardwired, both fed the same stimulus.
module tb_bus_load_bank;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] bus_in;
  logic        wr_en;
  logic [4:0]  wr_sel;
  logic [3:0]  wr_be;

  logic [31:0] ra [32];
  logic [31:0] rb [32];
  logic [31:0] va, vb;
  logic        aa, ab;
  logic [4:0]  la, lb;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_load_bank #(.DATA_W(32), .ZERO_R0(1'b0)) u_a (
    .clk(clk), .clr(clr), .bus_in(bus_in), .wr_en(wr_en),
    .wr_sel(wr_sel), .wr_be(wr_be),
    .r0(ra[0]), .r1(ra[1]), .r2(ra[2]), .r3(ra[3]),
    .r4(ra[4]), .r5(ra[5]), .r6(ra[6]), .r7(ra[7]),
    .r8(ra[8]), .r9(ra[9]), .r10(ra[10]), .r11(ra[11]),
    .r12(ra[12]), .r13(ra[13]), .r14(ra[14]), .r15(ra[15]),
    .r16(ra[16]), .r17(ra[17]), .r18(ra[18]), .r19(ra[19]),
    .r20(ra[20]), .r21(ra[21]), .r22(ra[22]), .r23(ra[23]),
    .r24(ra[24]), .r25(ra[25]), .r26(ra[26]), .r27(ra[27]),
    .r28(ra[28]), .r29(ra[29]), .r30(ra[30]), .r31(ra[31]),
    .valid(va), .wr_ack(aa), .last_sel(la)
  );

  bus_load_bank #(.DATA_W(32), .ZERO_R0(1'b1)) u_b (
    .clk(clk), .clr(clr), .bus_in(bus_in), .wr_en(wr_en),
    .wr_sel(wr_sel), .wr_be(wr_be),
    .r0(rb[0]), .r1(rb[1]), .r2(rb[2]), .r3(rb[3]),
    .r4(rb[4]), .r5(rb[5]), .r6(rb[6]), .r7(rb[7]),
    .r8(rb[8]), .r9(rb[9]), .r10(rb[10]), .r11(rb[11]),
    .r12(rb[12]), .r13(rb[13]), .r14(rb[14]), .r15(rb[15]),
    .r16(rb[16]), .r17(rb[17]), .r18(rb[18]), .r19(rb[19]),
    .r20(rb[20]), .r21(rb[21]), .r22(rb[22]), .r23(rb[23]),
    .r24(rb[24]), .r25(rb[25]), .r26(rb[26]), .r27(rb[27]),
    .r28(rb[28]), .r29(rb[29]), .r30(rb[30]), .r31(rb[31]),
    .valid(vb), .wr_ack(ab), .last_sel(lb)
  );

  typedef struct {
    logic        en;
    logic [4:0]  sel;
    logic [3:0]  be;
    logic [31:0] d;
    logic [4:0]  ci;
    logic [31:0] er;
    logic [31:0] ev;
    logic        ea;
    logic [4:0]  el;
  } vec_t;

  vec_t tv [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [4:0] s, input logic [31:0] d,
                    input logic [3:0] be);
    wr_en  = 1'b1;
    wr_sel = s;
    bus_in = d;
    wr_be  = be;
    step();
    wr_en  = 1'b0;
  endtask

  initial begin
    tv[0] = '{1'b1, 5'd5,  4'hF, 32'hDEADBEEF, 5'd5,
              32'hDEADBEEF, 32'h0000_0020, 1'b1, 5'd5};
    tv[1] = '{1'b0, 5'd9,  4'hF, 32'h12345678, 5'd9,
              32'h0, 32'h0000_0020, 1'b0, 5'd5};
    tv[2] = '{1'b1, 5'd31, 4'hF, 32'h11223344, 5'd31,
              32'h11223344, 32'h8000_0020, 1'b1, 5'd31};
    tv[3] = '{1'b1, 5'd31, 4'b0101, 32'hAABBCCDD, 5'd31,
              32'h11BB33DD, 32'h8000_0020, 1'b1, 5'd31};
    tv[4] = '{1'b1, 5'd7,  4'h0, 32'hFFFFFFFF, 5'd7,
              32'h0, 32'h8000_0020, 1'b1, 5'd7};
    tv[5] = '{1'b1, 5'd0,  4'hF, 32'hFFFFFFFF, 5'd0,
              32'hFFFFFFFF, 32'h8000_0021, 1'b1, 5'd0};
    tv[6] = '{1'b1, 5'd5,  4'b0010, 32'h0000_7700, 5'd5,
              32'hDEAD77EF, 32'h8000_0021, 1'b1, 5'd5};
    tv[7] = '{1'b0, 5'd5,  4'hF, 32'h0, 5'd5,
              32'hDEAD77EF, 32'h8000_0021, 1'b0, 5'd5};

    clr = 1'b1; wr_en = 1'b0; wr_sel = '0; wr_be = '0; bus_in = '0;
    step();
    clr = 1'b0;

    // random traffic, then a single-cycle clear
    for (int i = 0; i < 4; i++)
      wr(5'($urandom_range(0, 31)), $urandom, 4'hF);
    clr = 1'b1;
    step();
    clr = 1'b0;
    begin
      logic [31:0] orr;
      orr = '0;
      for (int n = 0; n < 32; n++) orr = orr | ra[n] | rb[n];
      chk("reset_regs", orr, 32'h0);
    end
    chk("reset_valid", va, 32'h0);
    chk("reset_ack", {31'b0, aa}, 32'h0);
    chk("reset_last", {27'b0, la}, 32'h0);

    for (int i = 0; i < 8; i++) begin
      wr_en  = tv[i].en;
      wr_sel = tv[i].sel;
      wr_be  = tv[i].be;
      bus_in = tv[i].d;
      step();
      chk($sformatf("v%0d_r", i), ra[tv[i].ci], tv[i].er);
      chk($sformatf("v%0d_valid", i), va, tv[i].ev);
      chk($sformatf("v%0d_ack", i), {31'b0, aa}, {31'b0, tv[i].ea});
      chk($sformatf("v%0d_last", i), {27'b0, la}, {27'b0, tv[i].el});
    end
    wr_en = 1'b0;

    // hardwired entry 0 versus writable entry 0
    wr(5'd0, 32'hFFFFFFFF, 4'hF);
    chk("z0_a_r0", ra[0], 32'hFFFFFFFF);
    chk("z0_a_v0", {31'b0, va[0]}, 32'h1);
    chk("z1_b_r0", rb[0], 32'h0);
    chk("z1_b_v0", {31'b0, vb[0]}, 32'h0);
    chk("z1_b_ack", {31'b0, ab}, 32'h1);
    chk("z1_b_last", {27'b0, lb}, 32'h0);

    // clr and wr_en together: write dropped, no ack
    clr = 1'b1; wr_en = 1'b1; wr_sel = 5'd3; wr_be = 4'hF; bus_in = 32'h1;
    step();
    clr = 1'b0; wr_en = 1'b0;
    chk("clrwr_r3", ra[3], 32'h0);
    chk("clrwr_valid", va, 32'h0);
    chk("clrwr_ack0", {31'b0, aa}, 32'h0);
    step();
    chk("clrwr_ack1", {31'b0, aa}, 32'h0);

    // clr right after a write kills the pending ack
    wr(5'd4, 32'hCAFE0001, 4'hF);
    chk("pre_clr_ack", {31'b0, aa}, 32'h1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("post_clr_ack", {31'b0, aa}, 32'h0);
    chk("post_clr_r4", ra[4], 32'h0);

    // back-to-back sweep over every entry
    for (int s = 0; s < 32; s++) begin
      wr_en  = 1'b1;
      wr_sel = 5'(s);
      wr_be  = 4'hF;
      bus_in = 32'(s) * 32'h01010101;
      step();
      chk($sformatf("sweep_ack%0d", s), {31'b0, aa}, 32'h1);
      chk($sformatf("sweep_last%0d", s), {27'b0, la}, 32'(s));
    end
    wr_en = 1'b0;
    step();
    chk("sweep_ack_end", {31'b0, aa}, 32'h0);
    for (int s = 0; s < 32; s++)
      chk($sformatf("sweep_r%0d", s), ra[s], 32'(s) * 32'h01010101);
    chk("sweep_valid_a", va, 32'hFFFFFFFF);
    chk("sweep_valid_b", vb, 32'hFFFFFFFE);
    chk("sweep_b_r0", rb[0], 32'h0);
    chk("sweep_b_r31", rb[31], 32'h1F1F1F1F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
